// File: rtl/riscv_pipe_pkg.sv
// Shared types, opcode constants and small decode helpers for the fetch pipeline.
package riscv_pipe_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MD_WAIT = 2'd1,
        DONE    = 2'd2
    } seq_state_t;

    localparam logic [6:0]  OP_JUMP    = 7'b1100011;
    localparam logic [6:0]  OP_R       = 7'b0110011;
    localparam logic [6:0]  OP_ACCDIV  = 7'b1011111;
    localparam logic [6:0]  FUNCT7_MUL = 7'b0000001;
    localparam logic [31:0] NOP        = 32'h0;

    function automatic logic [4:0] rs1_of(input logic [31:0] inst);
        return inst[19:15];
    endfunction

    function automatic logic [4:0] rs2_of(input logic [31:0] inst);
        return inst[24:20];
    endfunction

    function automatic logic is_jump(input logic [31:0] inst);
        return inst[6:0] == OP_JUMP;
    endfunction

    function automatic logic is_muldiv(input logic [31:0] inst);
        return ((inst[6:0] == OP_R) && (inst[31:25] == FUNCT7_MUL)) ||
               (inst[6:0] == OP_ACCDIV);
    endfunction

    function automatic logic is_nop(input logic [31:0] inst);
        return inst == NOP;
    endfunction

endpackage

// File: rtl/lu_hazard_detect.sv
// Load-use hazard detect: ID source registers against the destination of a load in EX.
module lu_hazard_detect
    import riscv_pipe_pkg::*;
#(
    parameter bit LU_STALL = 1'b0
) (
    input  logic        id_valid,
    input  logic [31:0] id_inst,
    input  logic        ex_memread,
    input  logic [4:0]  ex_rd,
    output logic        hazard
);

    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       unused_inst_bits;

    assign rs1 = rs1_of(id_inst);
    assign rs2 = rs2_of(id_inst);
    assign unused_inst_bits = ^{id_inst[31:25], id_inst[14:0]};

    // Stall only when forwarding is disabled and a real ID instruction reads the loaded register
    always_comb begin
        hazard = LU_STALL && id_valid && ex_memread && (ex_rd != '0) &&
                 ((ex_rd == rs1) || (ex_rd == rs2));
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Program counter owner and IF / IF-ID sequencer: advance, load-use hold, jump redirect,
// mul/div freeze and halt at end of instruction memory.
module fetch_sequencer
    import riscv_pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_BYTES = 100,
    parameter int unsigned MD_CYCLES  = 4,
    parameter bit          LU_STALL   = 1'b0
) (
    input  logic        clk,
    input  logic        res,
    input  logic        id_valid,
    input  logic [31:0] id_inst,
    input  logic        id_branch,
    input  logic [31:0] id_target,
    input  logic        id_muldiv,
    input  logic        ex_memread,
    input  logic [4:0]  ex_rd,
    output logic [31:0] pc,
    output logic        pc_we,
    output logic        if_id_we,
    output logic        if_id_flush,
    output logic        id_ex_bubble,
    output logic        md_start,
    output logic        md_done,
    output logic        halted,
    output logic [31:0] stall_cycles
);

    localparam int unsigned CW       = $clog2(MD_CYCLES) + 1;
    localparam logic [32:0] PC_LIMIT = 33'(IMEM_BYTES - 4);
    localparam logic [CW-1:0] MD_LOAD = CW'(MD_CYCLES - 1);

    seq_state_t    state, state_nx;
    logic [31:0]   pc_nx;
    logic [CW-1:0] md_cnt, md_cnt_nx;
    logic          hazard;
    logic [32:0]   seq_pc;
    logic [32:0]   jmp_pc;
    logic          unused_target_bits;

    // 33-bit candidates so an overflow past 2^32 is seen as out of range, never as a wrap
    assign seq_pc = {1'b0, pc} + 33'd4;
    assign jmp_pc = {1'b0, id_target[31:2], 2'b00};
    assign unused_target_bits = ^id_target[1:0];

    lu_hazard_detect #(
        .LU_STALL (LU_STALL)
    ) u_lu_hazard (
        .id_valid   (id_valid),
        .id_inst    (id_inst),
        .ex_memread (ex_memread),
        .ex_rd      (ex_rd),
        .hazard     (hazard)
    );

    // Next-state, next-pc and pipeline control decode
    always_comb begin
        state_nx     = state;
        pc_nx        = pc;
        md_cnt_nx    = md_cnt;
        pc_we        = 1'b0;
        if_id_we     = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        md_start     = 1'b0;
        md_done      = 1'b0;
        halted       = 1'b0;
        if (res) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else begin
            unique case (state)
                RUN: begin
                    if (hazard) begin
                        id_ex_bubble = 1'b1;
                    end else if (id_valid && id_branch) begin
                        if_id_flush = 1'b1;
                        if (jmp_pc > PC_LIMIT) begin
                            state_nx = DONE;
                        end else begin
                            pc_nx = jmp_pc[31:0];
                            pc_we = 1'b1;
                        end
                    end else if (id_valid && id_muldiv) begin
                        md_start     = 1'b1;
                        id_ex_bubble = 1'b1;
                        md_cnt_nx    = MD_LOAD;
                        state_nx     = MD_WAIT;
                    end else if (seq_pc > PC_LIMIT) begin
                        if_id_flush = 1'b1;
                        state_nx    = DONE;
                    end else begin
                        pc_nx    = seq_pc[31:0];
                        pc_we    = 1'b1;
                        if_id_we = 1'b1;
                    end
                end
                MD_WAIT: begin
                    if (md_cnt != '0) begin
                        id_ex_bubble = 1'b1;
                        md_cnt_nx    = md_cnt - 1'b1;
                    end else begin
                        // Release happens here, not in RUN, so the held mul/div never restarts
                        md_done = 1'b1;
                        if (seq_pc > PC_LIMIT) begin
                            if_id_flush = 1'b1;
                            state_nx    = DONE;
                        end else begin
                            pc_nx    = seq_pc[31:0];
                            pc_we    = 1'b1;
                            if_id_we = 1'b1;
                            state_nx = RUN;
                        end
                    end
                end
                DONE: begin
                    if_id_flush = 1'b1;
                    halted      = 1'b1;
                end
                default: begin
                    state_nx = RUN;
                end
            endcase
        end
    end

    // State, pc, mul/div countdown and saturating stall counter registers
    always_ff @(posedge clk) begin
        if (res) begin
            pc           <= RESET_PC;
            state        <= RUN;
            md_cnt       <= '0;
            stall_cycles <= '0;
        end else begin
            pc     <= pc_nx;
            state  <= state_nx;
            md_cnt <= md_cnt_nx;
            if ((state != DONE) && !pc_we && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: two instances (load-use stall on / forwarding) driven with
// identical directed and random stimulus, each checked against a cycle-level reference model.
module tb_fetch_sequencer;
    import riscv_pipe_pkg::*;

    localparam int unsigned MDC   = 4;
    localparam int unsigned IMEM  = 100;
    localparam int unsigned LIMIT = IMEM - 4;

    logic        clk = 1'b0;
    logic        res;
    logic        id_valid;
    logic [31:0] id_inst;
    logic        id_branch;
    logic [31:0] id_target;
    logic        id_muldiv;
    logic        ex_memread;
    logic [4:0]  ex_rd;

    logic [31:0] pc_o [2];
    logic [31:0] stall_o [2];
    logic [1:0]  pc_we_o, if_id_we_o, flush_o, bub_o, ms_o, md_o, halt_o;

    int checks = 0;
    int errors = 0;

    // reference model state, index 0 = stall-on instance, 1 = forwarding instance
    int unsigned m_pc [2];
    int          m_wait [2];
    bit          m_done [2];
    longint      m_stall [2];
    bit          m_known = 1'b0;

    always #5 clk = ~clk;

    fetch_sequencer #(
        .RESET_PC   (32'h0),
        .IMEM_BYTES (IMEM),
        .MD_CYCLES  (MDC),
        .LU_STALL   (1'b1)
    ) dut_stall (
        .clk (clk), .res (res), .id_valid (id_valid), .id_inst (id_inst),
        .id_branch (id_branch), .id_target (id_target), .id_muldiv (id_muldiv),
        .ex_memread (ex_memread), .ex_rd (ex_rd),
        .pc (pc_o[0]), .pc_we (pc_we_o[0]), .if_id_we (if_id_we_o[0]),
        .if_id_flush (flush_o[0]), .id_ex_bubble (bub_o[0]), .md_start (ms_o[0]),
        .md_done (md_o[0]), .halted (halt_o[0]), .stall_cycles (stall_o[0])
    );

    fetch_sequencer #(
        .RESET_PC   (32'h0),
        .IMEM_BYTES (IMEM),
        .MD_CYCLES  (MDC),
        .LU_STALL   (1'b0)
    ) dut_fwd (
        .clk (clk), .res (res), .id_valid (id_valid), .id_inst (id_inst),
        .id_branch (id_branch), .id_target (id_target), .id_muldiv (id_muldiv),
        .ex_memread (ex_memread), .ex_rd (ex_rd),
        .pc (pc_o[1]), .pc_we (pc_we_o[1]), .if_id_we (if_id_we_o[1]),
        .if_id_flush (flush_o[1]), .id_ex_bubble (bub_o[1]), .md_start (ms_o[1]),
        .md_done (md_o[1]), .halted (halt_o[1]), .stall_cycles (stall_o[1])
    );

    function automatic logic [31:0] mk_inst(input logic [6:0] f7, input logic [4:0] rs2,
                                            input logic [4:0] rs1, input logic [4:0] rd,
                                            input logic [6:0] op);
        return {f7, rs2, rs1, 3'b000, rd, op};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs against the model before the edge, then advance the model
    task automatic step();
        logic [6:0]  ev [2];   // {pc_we, if_id_we, flush, bubble, md_start, md_done, halted}
        int unsigned np [2];
        int          nw [2];
        bit          nd [2];
        bit          haz, adv;
        int unsigned tgt;
        #1;
        for (int d = 0; d < 2; d++) begin
            ev[d] = '0; np[d] = m_pc[d]; nw[d] = m_wait[d]; nd[d] = m_done[d]; adv = 1'b0;
            haz = (d == 0) && id_valid && ex_memread && (ex_rd != 0) &&
                  ((ex_rd == id_inst[19:15]) || (ex_rd == id_inst[24:20]));
            if (res) begin
                ev[d] = 7'b0011000;
            end else if (m_done[d]) begin
                ev[d] = 7'b0010001;
            end else if (m_wait[d] > 1) begin
                ev[d][3] = 1'b1; nw[d] = m_wait[d] - 1;
            end else if (m_wait[d] == 1) begin
                ev[d][1] = 1'b1; nw[d] = 0; adv = 1'b1;
            end else if (haz) begin
                ev[d][3] = 1'b1;
            end else if (id_valid && id_branch) begin
                tgt = id_target & 32'hFFFF_FFFC;
                ev[d][4] = 1'b1;
                if (tgt <= LIMIT) begin ev[d][6] = 1'b1; np[d] = tgt; end
                else nd[d] = 1'b1;
            end else if (id_valid && id_muldiv) begin
                ev[d][2] = 1'b1; ev[d][3] = 1'b1; nw[d] = MDC;
            end else begin
                adv = 1'b1;
            end
            if (adv) begin
                if (m_pc[d] + 4 <= LIMIT) begin
                    ev[d][6] = 1'b1; ev[d][5] = 1'b1; np[d] = m_pc[d] + 4;
                end else begin
                    ev[d][4] = 1'b1; nd[d] = 1'b1;
                end
            end
            chk($sformatf("ctrl[%0d]", d),
                32'({pc_we_o[d], if_id_we_o[d], flush_o[d], bub_o[d], ms_o[d], md_o[d], halt_o[d]}),
                32'(ev[d]));
            if (m_known) begin
                chk($sformatf("pc[%0d]", d), pc_o[d], m_pc[d]);
                chk($sformatf("stall[%0d]", d), stall_o[d], 32'(m_stall[d]));
            end
        end
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (res) begin
                m_pc[d] = 0; m_wait[d] = 0; m_done[d] = 1'b0; m_stall[d] = 0;
            end else begin
                if (!m_done[d] && !ev[d][6] && m_stall[d] < 64'h0000_0000_FFFF_FFFF) m_stall[d]++;
                m_pc[d] = np[d]; m_wait[d] = nw[d]; m_done[d] = nd[d];
            end
        end
        if (res) m_known = 1'b1;
        @(negedge clk);
    endtask

    task automatic plain();
        res = 1'b0; id_valid = 1'b1; id_branch = 1'b0; id_muldiv = 1'b0; ex_memread = 1'b0;
        id_inst = mk_inst(7'd0, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                          5'($urandom_range(1, 31)), OP_R);
        id_target = $urandom; ex_rd = 5'($urandom_range(0, 31));
    endtask

    task automatic do_reset();
        plain(); res = 1'b1; step(); step(); res = 1'b0;
    endtask

    initial begin
        res = 1'b1; id_valid = 1'b0; id_inst = NOP; id_branch = 1'b0; id_target = '0;
        id_muldiv = 1'b0; ex_memread = 1'b0; ex_rd = '0;
        @(negedge clk);

        // reset, then plain sequential fetch 0..52
        do_reset();
        chk("reset_pc", pc_o[0], 32'h0);
        for (int i = 0; i < 13; i++) begin plain(); step(); end
        chk("pc_at_52", pc_o[0], 32'd52);

        // jump 52 -> 60
        plain(); id_inst = mk_inst(7'd0, 5'd0, 5'd0, 5'd0, OP_JUMP);
        id_branch = is_jump(id_inst); id_target = 32'd60; step();
        chk("jump_pc", pc_o[0], 32'd60);
        plain(); step();

        // mul/div freeze with ID holding the mul throughout
        plain(); id_inst = mk_inst(FUNCT7_MUL, 5'd7, 5'd6, 5'd8, OP_R);
        id_muldiv = is_muldiv(id_inst);
        for (int i = 0; i < int'(MDC) + 1; i++) step();
        chk("md_stalls", stall_o[1], 32'd4);
        plain(); step(); plain(); step();

        // load-use: lw x3 in EX, add x2,x3,x5 in ID
        plain(); ex_memread = 1'b1; ex_rd = 5'd3;
        id_inst = mk_inst(7'd0, 5'd5, 5'd3, 5'd2, OP_R); step();
        plain(); step();
        plain(); ex_memread = 1'b1; ex_rd = 5'd0;
        id_inst = mk_inst(7'd0, 5'd0, 5'd0, 5'd2, OP_R); step();
        plain(); id_valid = 1'b0; ex_memread = 1'b1; ex_rd = 5'd4;
        id_inst = mk_inst(7'd0, 5'd4, 5'd4, 5'd1, OP_R); step();
        chk("lu_stall_count", stall_o[0] - stall_o[1], 32'd1);

        // run into end of memory
        for (int i = 0; i < 40 && pc_o[0] != 32'd96; i++) begin plain(); step(); end
        for (int i = 0; i < 3; i++) begin plain(); step(); end
        chk("end_pc", pc_o[0], 32'd96);
        chk("end_halted", 32'(halt_o), 32'h3);

        // out-of-range jump halts with pc unchanged
        do_reset();
        plain(); id_branch = 1'b1; id_target = 32'd200; step();
        plain(); step();
        chk("far_jump_pc", pc_o[0], 32'h0);
        chk("far_jump_halted", 32'(halt_o[0]), 32'h1);

        // reset in the second MD_WAIT cycle aborts the freeze
        do_reset();
        plain(); id_muldiv = 1'b1; step(); step();
        res = 1'b1; step();
        plain(); step();
        chk("md_abort_pc", pc_o[0], 32'h4);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            res        = ($urandom_range(0, 59) == 0);
            id_valid   = ($urandom_range(0, 7) != 0);
            id_inst    = mk_inst(($urandom_range(0, 1) == 1) ? FUNCT7_MUL : 7'd0,
                                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                                 5'($urandom_range(0, 31)),
                                 ($urandom_range(0, 9) == 0) ? OP_ACCDIV : OP_R);
            id_muldiv  = is_muldiv(id_inst) && ($urandom_range(0, 3) == 0);
            id_branch  = ($urandom_range(0, 5) == 0);
            id_target  = $urandom_range(0, 127);
            ex_memread = ($urandom_range(0, 2) == 0);
            ex_rd      = 5'($urandom_range(0, 3));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Owns the program counter and sequences the IF stage and the IF/ID pipeline register.
- Sits between the ID-stage decode (jump/branch, mul/div detect, jump-target generator) and the instruction memory / if_id register.
- Decides each cycle whether to advance, hold for a load-use hazard, redirect on a jump, freeze for a multi-cycle mul/div, or halt at end of instruction memory.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- IMEM_BYTES, 100, instruction memory size in bytes; the highest legal fetch PC is IMEM_BYTES-4
- MD_CYCLES, 4, fixed latency of the mul/div/accumulator-divide unit in cycles; must be >= 1
- LU_STALL, 0, 1 = insert a one-cycle load-use stall; 0 = load data is forwarded and no stall is inserted

Ports:
- clk  in  1  clock
- res  in  1  reset, synchronous, active-high
- id_valid  in  1  ID stage holds a real instruction (not a bubble)
- id_inst  in  32  instruction currently in ID
- id_branch  in  1  ID instruction is a jump (opcode 1100011)
- id_target  in  32  jump target from the address generator
- id_muldiv  in  1  ID instruction is MUL (funct7 0000001) or accumulator divide (opcode 1011111)
- ex_memread  in  1  instruction in EX is a load
- ex_rd  in  5  destination register of the instruction in EX
- pc  out  32  current fetch address
- pc_we  out  1  fetch advances this cycle
- if_id_we  out  1  if_id register captures the new instruction
- if_id_flush  out  1  if_id loads NOP (all zeros); takes priority over if_id_we
- id_ex_bubble  out  1  ID/EX register loads zeros instead of the ID instruction
- md_start  out  1  one-cycle start pulse to the mul/div unit
- md_done  out  1  mul/div result valid; ID instruction released to EX
- halted  out  1  sequencer is in DONE
- stall_cycles  out  32  performance counter

Behaviour:
- States: RUN, MD_WAIT, DONE. Registers: pc, state, md_cnt (width clog2(MD_CYCLES)+1), stall_cycles.
- Reset (res=1 at posedge):
  - pc=RESET_PC, state=RUN, md_cnt=0, stall_cycles=0.
  - While res=1: pc_we=0, if_id_we=0, if_id_flush=1, id_ex_bubble=1, md_start=0, md_done=0, halted=0.
  - Reset mid-MD_WAIT or in DONE aborts immediately; no md_done is issued.
- The lu hazard is true when all of the following hold: LU_STALL=1, id_valid, ex_memread, ex_rd!=0, and ex_rd equals id_inst[19:15] or id_inst[24:20].
- RUN priority, highest first:
  - 1. lu hazard: pc_we=0, if_id_we=0, id_ex_bubble=1. Stays in RUN. Lasts exactly 1 cycle because ex_memread clears next cycle.
  - 2. id_valid & id_branch: pc <= {id_target[31:2],2'b00}, pc_we=1, if_id_flush=1 (discards the fall-through fetch). Penalty is 1 bubble.
  - 3. id_valid & id_muldiv: md_start=1, pc_we=0, if_id_we=0, id_ex_bubble=1, md_cnt <= MD_CYCLES-1, go to MD_WAIT.
  - 4. Otherwise: pc <= pc+4, pc_we=1, if_id_we=1.
- MD_WAIT:
  - While md_cnt!=0: hold pc and if_id, id_ex_bubble=1, md_cnt decrements.
  - When md_cnt==0: md_done=1, id_ex_bubble=0, pc <= pc+4, pc_we=1, if_id_we=1, go to RUN.
  - Total freeze is MD_CYCLES+1 cycles from md_start to md_done inclusive.
  - The mul/div instruction is not re-triggered: its release cycle occurs in MD_WAIT, not RUN.
- End of memory: any pc update whose new value is > IMEM_BYTES-4 (sequential or jump) is not performed.
  - pc holds, if_id_flush=1, and the state goes to DONE.
  - Wrap-around is never allowed.
- DONE: pc frozen, pc_we=0, if_id_flush=1, id_ex_bubble=0 (the pipeline drains), halted=1. Only res exits DONE.
- id_valid=0: id_branch, id_muldiv and the hazard are ignored.
- Simultaneous jump + lu hazard: the stall wins and the jump is taken on the following cycle.
- stall_cycles increments on every cycle with state!=DONE, res=0, pc_we=0. It saturates at 32'hFFFF_FFFF.

Decomposition:
- Package riscv_pipe_pkg holds:
  - state enum {RUN, MD_WAIT, DONE}
  - opcode constants OP_JUMP=7'b1100011, OP_R=7'b0110011, OP_ACCDIV=7'b1011111
  - FUNCT7_MUL=7'b0000001
  - NOP=32'h0
- One sub-module, lu_hazard_detect: combinational rs1/rs2 vs ex_rd compare, gated by LU_STALL. The FSM, pc register and counter stay in fetch_sequencer.

Test Plan:
- Reset then 5 plain ADDs -> pc steps 0,4,8,12,16,20; pc_we=1 every cycle; stall_cycles=0.
- ID jump at pc=52 with id_target=60 -> next pc=60; if_id_flush=1 for exactly 1 cycle; no md_start.
- MUL in ID with MD_CYCLES=4 -> md_start 1 cycle; pc held 4 cycles; md_done on cycle 5; pc+4 next; stall_cycles=4; no second md_start.
- LU_STALL=1, lw x3 in EX, add x2,x3,x5 in ID -> one bubble and pc held 1 cycle. LU_STALL=0 with the same stimulus -> no stall. ex_rd=0 -> no stall.
- Sequential fetch reaching pc=96 with IMEM_BYTES=100 -> pc stays 96; halted=1; if_id_flush=1 continuously. Jump to 200 -> also DONE with pc unchanged.
- Assert res during MD_WAIT cycle 2 -> next cycle pc=RESET_PC, state RUN, md_done never asserted, stall_cycles=0.
